// File: rtl/cond_unit_pipe_pkg.sv
// Shared types and constants for the ARM-style condition unit.
package cond_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  localparam int unsigned N_IDX = 3;
  localparam int unsigned Z_IDX = 2;
  localparam int unsigned C_IDX = 1;
  localparam int unsigned V_IDX = 0;

  localparam logic [3:0] FLAG_RST_DEFAULT = 4'b0000;

endpackage

// File: rtl/cond_unit_pipe_if.sv
// E-stage decode intents in, branch/writeback controls and flags out.
// SquashCnt exists only when COND_UNIT_SQUASH_CNT_EN is defined.
interface cond_unit_pipe_if;
  logic       ValidE;
  logic       StallE;
  logic       FlushE;
  logic       PCSE;
  logic       RegWE;
  logic       MemWE;
  logic       NoWriteE;
  logic [1:0] FlagWE;
  logic [3:0] CondE;
  logic [3:0] ALUFlags;
  logic       PCSrcE;
  logic       CondExE;
  logic       MemWriteM;
  logic       RegWriteOut;
  logic [3:0] Flags;
`ifdef COND_UNIT_SQUASH_CNT_EN
  logic [15:0] SquashCnt;
`endif

  modport master (
    output ValidE, StallE, FlushE, PCSE, RegWE, MemWE, NoWriteE, FlagWE, CondE, ALUFlags,
    input  PCSrcE, CondExE, MemWriteM, RegWriteOut, Flags
`ifdef COND_UNIT_SQUASH_CNT_EN
    , input SquashCnt
`endif
  );

  modport slave (
    input  ValidE, StallE, FlushE, PCSE, RegWE, MemWE, NoWriteE, FlagWE, CondE, ALUFlags,
    output PCSrcE, CondExE, MemWriteM, RegWriteOut, Flags
`ifdef COND_UNIT_SQUASH_CNT_EN
    , output SquashCnt
`endif
  );
endinterface

// File: rtl/cond_unit_pipe_cond_eval.sv
// Pure combinational ARM condition check of CondE against NZCV flags.
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       cond_ex_o
);

  logic n, z, c, v;

  always_comb begin
    n = flags_i[N_IDX];
    z = flags_i[Z_IDX];
    c = flags_i[C_IDX];
    v = flags_i[V_IDX];
    cond_ex_o = 1'b0;
    case (cond_e'(cond_i))
      COND_EQ: cond_ex_o = z;
      COND_NE: cond_ex_o = ~z;
      COND_CS: cond_ex_o = c;
      COND_CC: cond_ex_o = ~c;
      COND_MI: cond_ex_o = n;
      COND_PL: cond_ex_o = ~n;
      COND_VS: cond_ex_o = v;
      COND_VC: cond_ex_o = ~v;
      COND_HI: cond_ex_o = c & ~z;
      COND_LS: cond_ex_o = ~c | z;
      COND_GE: cond_ex_o = (n == v);
      COND_LT: cond_ex_o = (n != v);
      COND_GT: cond_ex_o = ~z & (n == v);
      COND_LE: cond_ex_o = z | (n != v);
      COND_AL: cond_ex_o = 1'b1;
      default: cond_ex_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit_pipe.sv
// Condition unit: NZCV register, E-stage fire decision, writeback pipe of PIPE_DEPTH (1..4).
// Optional squash counter enabled by COND_UNIT_SQUASH_CNT_EN.
module cond_unit_pipe
  import cond_pkg::*;
#(
  parameter int unsigned PIPE_DEPTH = 2,
  parameter logic [3:0]  FLAG_RST   = FLAG_RST_DEFAULT
) (
  input logic             clk,
  input logic             reset,
  cond_unit_pipe_if.slave bus
);

  logic                  cond_ex;
  logic                  fire;
  logic [3:0]            flags_d, flags_q;
  logic                  regw_d, memw_d;
  logic                  memw_q;
  logic [PIPE_DEPTH-1:0] regw_q;
  logic [PIPE_DEPTH:0]   regw_shift;

  // Flags are the registered copy, so a flag setter and its dependant can issue back to back.
  cond_eval u_eval (
    .cond_i   (bus.CondE),
    .flags_i  (flags_q),
    .cond_ex_o(cond_ex)
  );

  always_comb begin
    fire    = bus.ValidE & cond_ex & ~bus.StallE & ~bus.FlushE;
    regw_d  = fire & bus.RegWE & ~bus.NoWriteE;
    memw_d  = fire & bus.MemWE;
    flags_d = flags_q;
    if (fire && bus.FlagWE[1]) begin
      flags_d[N_IDX] = bus.ALUFlags[N_IDX];
      flags_d[Z_IDX] = bus.ALUFlags[Z_IDX];
    end
    if (fire && bus.FlagWE[0]) begin
      flags_d[C_IDX] = bus.ALUFlags[C_IDX];
      flags_d[V_IDX] = bus.ALUFlags[V_IDX];
    end
  end

  assign regw_shift = {regw_q, regw_d};

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= FLAG_RST;
      memw_q  <= 1'b0;
      regw_q  <= '0;
    end else begin
      flags_q <= flags_d;
      memw_q  <= memw_d;
      regw_q  <= regw_shift[PIPE_DEPTH-1:0];
    end
  end

  assign bus.CondExE     = cond_ex;
  assign bus.PCSrcE      = fire & bus.PCSE;
  assign bus.Flags       = flags_q;
  assign bus.MemWriteM   = memw_q;
  assign bus.RegWriteOut = regw_q[PIPE_DEPTH-1];

`ifdef COND_UNIT_SQUASH_CNT_EN
  logic        squash;
  logic [15:0] squash_q;

  assign squash = bus.ValidE & ~cond_ex & ~bus.StallE & ~bus.FlushE;

  always_ff @(posedge clk) begin
    if (reset) begin
      squash_q <= '0;
    end else if (squash && (squash_q != '1)) begin
      squash_q <= squash_q + 16'd1;
    end
  end

  assign bus.SquashCnt = squash_q;
`endif

endmodule

// File: tb/tb_cond_unit_pipe.sv
// Directed plus random checks of cond_unit_pipe (PIPE_DEPTH=3) against an arithmetic reference model.
module tb_cond_unit_pipe;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  cond_unit_pipe_if bus ();

  cond_unit_pipe #(.PIPE_DEPTH(3), .FLAG_RST(4'b0000)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // reference state
  logic [3:0] flags_m;
  logic       mw_m;
  logic       rw_q[$];
  int         sq_m;

  function automatic logic model_pass(logic [3:0] c, logic [3:0] f);
    logic n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    if (c == 4'hE) return 1'b1;
    if (c == 4'hF) return 1'b0;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: base = 1'b0;
    endcase
    return base ^ c[0];
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic f, input logic pcs,
                       input logic rw, input logic mw, input logic nw, input logic [1:0] fw,
                       input logic [3:0] c, input logic [3:0] alu);
    bus.ValidE = v; bus.StallE = s; bus.FlushE = f; bus.PCSE = pcs;
    bus.RegWE = rw; bus.MemWE = mw; bus.NoWriteE = nw; bus.FlagWE = fw;
    bus.CondE = c; bus.ALUFlags = alu;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'hE, 4'h0);
  endtask

  // One clock: check combinational outputs mid-cycle, then registered outputs after the edge.
  task automatic cycle();
    logic       pass_m, fire_m, sq_ev;
    logic [3:0] mask, nflags;
    @(negedge clk);
    pass_m = model_pass(bus.CondE, flags_m);
    fire_m = bus.ValidE & pass_m & ~bus.StallE & ~bus.FlushE;
    sq_ev  = bus.ValidE & ~pass_m & ~bus.StallE & ~bus.FlushE;
    chk("CondExE", {15'd0, bus.CondExE}, {15'd0, pass_m});
    chk("PCSrcE", {15'd0, bus.PCSrcE}, {15'd0, fire_m & bus.PCSE});
    mask   = {{2{bus.FlagWE[1]}}, {2{bus.FlagWE[0]}}} & {4{fire_m}};
    nflags = (flags_m & ~mask) | (bus.ALUFlags & mask);
    @(posedge clk);
    if (reset) begin
      flags_m = 4'b0000;
      mw_m    = 1'b0;
      rw_q    = '{1'b0, 1'b0, 1'b0};
      sq_m    = 0;
    end else begin
      flags_m = nflags;
      mw_m    = fire_m & bus.MemWE;
      rw_q.push_back(fire_m & bus.RegWE & ~bus.NoWriteE);
      void'(rw_q.pop_front());
      if (sq_ev && sq_m < 65535) sq_m++;
    end
    #1;
    chk("Flags", {12'd0, bus.Flags}, {12'd0, flags_m});
    chk("MemWriteM", {15'd0, bus.MemWriteM}, {15'd0, mw_m});
    chk("RegWriteOut", {15'd0, bus.RegWriteOut}, {15'd0, rw_q[0]});
`ifdef COND_UNIT_SQUASH_CNT_EN
    chk("SquashCnt", bus.SquashCnt, 16'(sq_m));
`endif
  endtask

  initial begin
    flags_m = 4'b0000;
    mw_m    = 1'b0;
    rw_q    = '{1'b0, 1'b0, 1'b0};
    sq_m    = 0;
    reset   = 1'b1;
    idle();
    @(posedge clk); #1;
    cycle();
    cycle();
    chk("rst_flags", {12'd0, bus.Flags}, 16'h0000);
    chk("rst_rwo", {15'd0, bus.RegWriteOut}, 16'h0000);

    // EQ against cleared flags does not pass
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 4'h0, 4'hF);
    #1;
    chk("eq_condex", {15'd0, bus.CondExE}, 16'h0000);
    cycle();
    chk("eq_memw", {15'd0, bus.MemWriteM}, 16'h0000);

    // CMP sets Z, then BEQ sees it on the very next cycle
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 4'hE, 4'b0100);
    cycle();
    chk("cmp_flags", {12'd0, bus.Flags}, 16'h0004);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 4'h0);
    #1;
    chk("beq_pcsrc", {15'd0, bus.PCSrcE}, 16'h0001);
    cycle();
    idle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("cmp_norw", {15'd0, bus.RegWriteOut}, 16'h0000);
    end

    // partial flag write keeps C,V
    reset = 1'b1; idle(); cycle(); reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 4'hE, 4'hF);
    cycle();
    chk("nz_only", {12'd0, bus.Flags}, 16'h000C);

    // stall+flush, stall-only, then release
    reset = 1'b1; idle(); cycle(); reset = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 4'hE, 4'hF);
    cycle();
    chk("sf_memw", {15'd0, bus.MemWriteM}, 16'h0000);
    chk("sf_flags", {12'd0, bus.Flags}, 16'h0000);
    bus.FlushE = 1'b0;
    cycle();
    chk("st_memw", {15'd0, bus.MemWriteM}, 16'h0000);
    chk("st_flags", {12'd0, bus.Flags}, 16'h0000);
    bus.StallE = 1'b0;
    cycle();
    chk("rel_memw", {15'd0, bus.MemWriteM}, 16'h0001);
    chk("rel_flags", {12'd0, bus.Flags}, 16'h000F);

    // RegWrite emerges exactly three stages later
    idle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 4'hE, 4'h0);
    cycle();
    idle();
    chk("rw_t1", {15'd0, bus.RegWriteOut}, 16'h0000);
    cycle();
    chk("rw_t2", {15'd0, bus.RegWriteOut}, 16'h0000);
    cycle();
    chk("rw_t3", {15'd0, bus.RegWriteOut}, 16'h0001);
    cycle();
    chk("rw_t4", {15'd0, bus.RegWriteOut}, 16'h0000);

    // reset one cycle after issue drops the write
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 4'hE, 4'h0);
    cycle();
    idle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("rw_dropped", {15'd0, bus.RegWriteOut}, 16'h0000);
    end

    // random traffic
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(49, 0) == 0);
      drive(1'($urandom_range(3, 0) != 0), 1'($urandom_range(4, 0) == 0),
            1'($urandom_range(4, 0) == 0), 1'($urandom_range(1, 0)),
            1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
            1'($urandom_range(3, 0) == 0), 2'($urandom_range(3, 0)),
            4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)));
      cycle();
    end
    reset = 1'b0;

`ifdef COND_UNIT_SQUASH_CNT_EN
    reset = 1'b1; idle(); cycle(); reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 4'hE, 4'b0100);
    cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 4'h1, 4'h0);
    for (int i = 0; i < 3; i++) cycle();
    chk("sq_three", bus.SquashCnt, 16'd3);
    for (int i = 0; i < 65532; i++) cycle();
    chk("sq_full", bus.SquashCnt, 16'hFFFF);
    cycle();
    chk("sq_sat", bus.SquashCnt, 16'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cond_unit_pipe.md
COND_UNIT_PIPE -- requirements
Module: cond_unit_pipe

Interface
REQ-001 The block SHALL have parameter PIPE_DEPTH, default 2, range 1..4: stages from E to the RegWrite output.
REQ-002 The block SHALL have parameter FLAG_RST, default 4'b0000, giving the reset value of the NZCV flag register.
REQ-003 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 ValidE  in  1  an instruction is present in E.
REQ-007 StallE  in  1  the E instruction holds this cycle.
REQ-008 FlushE  in  1  the E instruction is killed.
REQ-009 PCSE, RegWE, MemWE, NoWriteE  in  1 each  decoder intents for the E instruction.
REQ-010 FlagWE  in  2  bit1 updates N,Z; bit0 updates C,V.
REQ-011 CondE  in  4  ARM condition field.
REQ-012 ALUFlags  in  4  [3]=N [2]=Z [1]=C [0]=V, from the E-stage ALU.
REQ-013 PCSrcE  out  1  branch taken, combinational in E.
REQ-014 CondExE  out  1  condition passed, combinational in E.
REQ-015 MemWriteM  out  1  registered, one stage after E.
REQ-016 RegWriteOut  out  1  registered, PIPE_DEPTH stages after E.
REQ-017 Flags  out  4  current NZCV register.

Function
REQ-018 CondExE SHALL be evaluated against the registered Flags, never against ALUFlags of the same instruction.
REQ-019 Encodings SHALL be: EQ Z, NE ~Z, CS C, CC ~C, MI N, PL ~N, VS V, VC ~V, HI C&~Z, LS ~C|Z, GE N==V, LT N!=V, GT ~Z&(N==V), LE Z|(N!=V), AL(1110) 1, 1111 0.
REQ-020 The E instruction fires when ValidE & CondExE & ~StallE & ~FlushE.
REQ-021 PCSrcE SHALL equal fire & PCSE.
REQ-022 On fire, Flags[3:2] SHALL load ALUFlags[3:2] if FlagWE[1]; Flags[1:0] SHALL load ALUFlags[1:0] if FlagWE[0]; otherwise Flags SHALL hold.
REQ-023 The M-stage register SHALL load {fire&RegWE&~NoWriteE, fire&MemWE}; on no-fire it SHALL load zeros (bubble).
REQ-024 Stages 2..PIPE_DEPTH SHALL advance every cycle, regardless of StallE.
REQ-025 Simultaneous StallE and FlushE SHALL behave as flush: bubble, no flag update.
REQ-026 NoWriteE=1 with FlagWE SHALL update Flags only (CMP behaviour).
REQ-027 Back-to-back flag-setting instructions SHALL each see the flags committed by the previous fired one, with zero-cycle turnaround.

Reset
REQ-028 While reset=1: Flags=FLAG_RST; all M..PIPE_DEPTH stage registers=0; MemWriteM=0; RegWriteOut=0.
REQ-029 Reset SHALL override fire in the same cycle.
REQ-030 An instruction in flight at reset SHALL be dropped; there is no partial write.

Configuration
REQ-031 Macro COND_UNIT_SQUASH_CNT_EN defined: a 16-bit output SquashCnt SHALL increment when ValidE & ~CondExE & ~StallE & ~FlushE, saturate at 16'hFFFF, and reset to 0.
REQ-032 Macro undefined: no SquashCnt port or logic.

Structure
REQ-033 Package cond_pkg SHALL hold the cond_e enum for the 16 encodings, the flag index constants N_IDX=3, Z_IDX=2, C_IDX=1, V_IDX=0, and the FLAG_RST default.
REQ-034 Sub-module cond_eval SHALL hold the pure-combinational (CondE, Flags) -> CondExE function; it is instantiated once.

Verification
REQ-035 Reset, then CondE=EQ, Flags=0000, ValidE=1 -> CondExE=0, PCSrcE=0, MemWriteM=0 next cycle.
REQ-036 CMP-like: NoWriteE=1, FlagWE=11, ALUFlags=0100 -> Flags=0100 next cycle, RegWriteOut stays 0; following BEQ with PCSE=1 -> PCSrcE=1.
REQ-037 FlagWE=10 with ALUFlags=1111 from Flags=0000 -> Flags=1100 (C,V held).
REQ-038 StallE=1 and FlushE=1 with AL store -> MemWriteM=0, Flags unchanged; same with StallE only -> same result, and the instruction fires on the cycle after StallE drops.
REQ-039 PIPE_DEPTH=3, AL RegWE=1 at cycle t -> RegWriteOut=1 at t+3 only; reset asserted at t+1 -> RegWriteOut never rises.
REQ-040 With COND_UNIT_SQUASH_CNT_EN: 3 failing NE instructions with Z=1 -> SquashCnt=3; preload 16'hFFFF, then one more -> stays 16'hFFFF.
